// File: rtl/issue_pair_if.sv
// Front-end to dual-issue handshake bundle: instruction stream in, issue pair out.
interface issue_pair_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instr0;
  logic [31:0] instr1;
  logic [5:0]  opcode;
  logic [5:0]  opcode1;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, instr0, instr1, opcode, opcode1
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, instr0, instr1, opcode, opcode1
  );
endinterface

// File: rtl/issue_pair.sv
// 4-entry instruction buffer feeding an ALU-slot / MEM-slot issue pair register.
// Define ISSUE_RAW_CHECK_EN to stop pairing when slot 1 reads slot 0's destination.
module issue_pair (
  input  logic         clk,
  input  logic         rst_n,
  issue_pair_if.slave  bus
);
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] instr0_q, instr0_d;
  logic [31:0] instr1_q, instr1_d;

  logic        push, load, hazard;
  logic [1:0]  pops;
  logic [31:0] head, nxt;

  function automatic logic is_mem(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011);
  endfunction

  assign bus.in_ready  = (count_q < 3'd4);
  assign bus.out_valid = out_valid_q;
  assign bus.instr0    = instr0_q;
  assign bus.instr1    = instr1_q;
  assign bus.opcode    = instr0_q[31:26];
  assign bus.opcode1   = instr1_q[31:26];

  assign push = bus.in_valid && bus.in_ready;
  assign load = (!out_valid_q || bus.out_ready) && (count_q != 3'd0);
  assign head = mem_q[rd_ptr_q];
  assign nxt  = mem_q[rd_ptr_q + 2'd1];

`ifdef ISSUE_RAW_CHECK_EN
  logic [4:0] dest0;
  always_comb begin
    dest0 = 5'd0;
    if (head[31:26] == 6'b000000 && head[5:0] == 6'b100000) dest0 = head[15:11];
    else if (head[31:26] == 6'b001000)                      dest0 = head[20:16];
  end
  // Base, sw data and lw dest all live in the same two fields of a MEM op.
  assign hazard = (dest0 != 5'd0) && ((dest0 == nxt[25:21]) || (dest0 == nxt[20:16]));
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    pops        = 2'd0;
    instr0_d    = instr0_q;
    instr1_d    = instr1_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
      if (is_mem(head[31:26])) begin
        instr0_d = NOP;
        instr1_d = head;
        pops     = 2'd1;
      end else if (count_q >= 3'd2 && is_mem(nxt[31:26]) && !hazard) begin
        instr0_d = head;
        instr1_d = nxt;
        pops     = 2'd2;
      end else begin
        instr0_d = head;
        instr1_d = NOP;
        pops     = 2'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    rd_ptr_d = rd_ptr_q + pops;
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    count_d  = count_q + {2'b00, push} - {1'b0, pops};

    // Taken branch: drop everything, including this cycle's push and load.
    if (bus.flush) begin
      rd_ptr_d    = 2'd0;
      wr_ptr_d    = 2'd0;
      count_d     = 3'd0;
      out_valid_d = 1'b0;
      instr0_d    = instr0_q;
      instr1_d    = instr1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      out_valid_q <= 1'b0;
      instr0_q    <= NOP;
      instr1_q    <= NOP;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      instr0_q    <= instr0_d;
      instr1_q    <= instr1_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wr_ptr_q] <= bus.in_instr;
  end
endmodule

// File: tb/tb_issue_pair.sv
// Self-checking bench for issue_pair: directed vector table, corner sequences, random vs queue model.
module tb_issue_pair;
  logic clk;
  logic rst_n;
  issue_pair_if bus ();

  issue_pair dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] F    = 32'h3C0A1234;
  localparam logic [31:0] ADDI = 32'h20010005;
  localparam logic [31:0] LW   = 32'h8C620000;
  localparam logic [31:0] LW2  = 32'h8C220000;
  localparam logic [31:0] SW   = 32'hAC010004;
  localparam logic [31:0] ADD  = 32'h00222020;

  // Reference model: buffer as a queue plus the visible pair.
  logic [31:0] mq [$];
  logic        m_ov;
  logic [31:0] m_i0, m_i1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit m_is_mem(input logic [31:0] x);
    return (x[31:26] == 6'h23) || (x[31:26] == 6'h2B);
  endfunction

  function automatic bit m_hazard(input logic [31:0] a, input logic [31:0] b);
`ifdef ISSUE_RAW_CHECK_EN
    int d;
    d = 0;
    if (a[31:26] == 6'h00 && a[5:0] == 6'h20) d = int'(a[15:11]);
    else if (a[31:26] == 6'h08) d = int'(a[20:16]);
    return (d != 0) && (d == int'(b[25:21]) || d == int'(b[20:16]));
`else
    return (a == b) && 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0;
    m_i0 = 32'h0;
    m_i1 = 32'h0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] ins, input logic ordy,
                            input logic fl, output logic rdy);
    logic [31:0] h;
    rdy = (mq.size() < 4);
    if (fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if ((!m_ov || ordy) && mq.size() != 0) begin
        h = mq.pop_front();
        m_ov = 1'b1;
        if (m_is_mem(h)) begin
          m_i0 = 32'h0; m_i1 = h;
        end else if (mq.size() >= 1 && m_is_mem(mq[0]) && !m_hazard(h, mq[0])) begin
          m_i0 = h; m_i1 = mq.pop_front();
        end else begin
          m_i0 = h; m_i1 = 32'h0;
        end
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (v && rdy) mq.push_back(ins);
    end
  endtask

  // Called at edge+1; returns at the next edge+1.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    logic rdy;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    bus.flush     = fl;
    model_step(v, ins, ordy, fl, rdy);
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
    @(posedge clk); #1;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
    if (m_ov) begin
      chk("instr0", bus.instr0, m_i0);
      chk("instr1", bus.instr1, m_i1);
      chk("opcode", {26'b0, bus.opcode}, {26'b0, m_i0[31:26]});
      chk("opcode1", {26'b0, bus.opcode1}, {26'b0, m_i1[31:26]});
    end
  endtask

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] gen();
    case ($urandom_range(0, 4))
      0: return {6'h23, rr(), rr(), 16'($urandom)};
      1: return {6'h2B, rr(), rr(), 16'($urandom)};
      2: return {6'h08, rr(), rr(), 16'($urandom)};
      3: return {6'h00, rr(), rr(), rr(), 5'd0, 6'h20};
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic        ordy;
    logic        ex_rdy;
    logic        ex_ov;
    logic [31:0] ex_i0;
    logic [31:0] ex_i1;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic ordy,
                              input logic ex_ov, input logic [31:0] i0, input logic [31:0] i1);
    vec_t t;
    t.v = v; t.ins = ins; t.ordy = ordy; t.ex_rdy = 1'b1;
    t.ex_ov = ex_ov; t.ex_i0 = i0; t.ex_i1 = i1;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lst [6];
    logic [31:0] acc [$];
    logic [31:0] iss [$];
    logic        r;

    // addi/lw independent pair; sw then add split; addi/lw with base hazard
    tbl[0]  = mk(1, F,    0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(1, ADDI, 0, 1, F,     32'h0);
    tbl[2]  = mk(1, LW,   0, 1, F,     32'h0);
    tbl[3]  = mk(0, 32'h0, 1, 1, ADDI, LW);
    tbl[4]  = mk(0, 32'h0, 1, 0, 32'h0, 32'h0);
    tbl[5]  = mk(1, F,    0, 0, 32'h0, 32'h0);
    tbl[6]  = mk(1, SW,   0, 1, F,     32'h0);
    tbl[7]  = mk(1, ADD,  0, 1, F,     32'h0);
    tbl[8]  = mk(0, 32'h0, 1, 1, 32'h0, SW);
    tbl[9]  = mk(0, 32'h0, 1, 1, ADD,  32'h0);
    tbl[10] = mk(0, 32'h0, 1, 0, 32'h0, 32'h0);
    tbl[11] = mk(1, F,    0, 0, 32'h0, 32'h0);
    tbl[12] = mk(1, ADDI, 0, 1, F,     32'h0);
    tbl[13] = mk(1, LW2,  0, 1, F,     32'h0);
`ifdef ISSUE_RAW_CHECK_EN
    tbl[14] = mk(0, 32'h0, 1, 1, ADDI, 32'h0);
    tbl[15] = mk(0, 32'h0, 1, 1, 32'h0, LW2);
`else
    tbl[14] = mk(0, 32'h0, 1, 1, ADDI, LW2);
    tbl[15] = mk(0, 32'h0, 1, 0, 32'h0, 32'h0);
`endif
    tbl[16] = mk(0, 32'h0, 1, 0, 32'h0, 32'h0);

    bus.in_valid = 0; bus.in_instr = 0; bus.out_ready = 0; bus.flush = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_instr0", bus.instr0, 32'h0);
    chk("rst_instr1", bus.instr1, 32'h0);
    chk("rst_opcode", {26'b0, bus.opcode}, 32'h0);
    chk("rst_opcode1", {26'b0, bus.opcode1}, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      chk("tbl_in_ready", {31'b0, bus.in_ready}, {31'b0, tbl[i].ex_rdy});
      step(tbl[i].v, tbl[i].ins, tbl[i].ordy, 1'b0);
      chk("tbl_out_valid", {31'b0, bus.out_valid}, {31'b0, tbl[i].ex_ov});
      if (tbl[i].ex_ov) begin
        chk("tbl_instr0", bus.instr0, tbl[i].ex_i0);
        chk("tbl_instr1", bus.instr1, tbl[i].ex_i1);
      end
    end

    // Backpressure: 1 in the pair register + 4 buffered, then drain in order.
    for (int k = 0; k < 6; k++) lst[k] = 32'h3C010000 + 32'(k);
    for (int k = 0; k < 8; k++) begin
      r = bus.in_ready;
      if (k < 6 && r) acc.push_back(lst[k]);
      step(k < 6, (k < 6) ? lst[k] : 32'h0, 1'b0, 1'b0);
    end
    chk("bp_accepted", 32'(acc.size()), 32'd5);
    chk("bp_in_ready", {31'b0, bus.in_ready}, 32'h0);
    chk("bp_hold_instr0", bus.instr0, lst[0]);
    chk("bp_hold_instr1", bus.instr1, 32'h0);
    if (bus.out_valid) begin
      if (bus.instr0 != 0) iss.push_back(bus.instr0);
      if (bus.instr1 != 0) iss.push_back(bus.instr1);
    end
    for (int k = 0; k < 20 && bus.out_valid; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (bus.out_valid) begin
        if (bus.instr0 != 0) iss.push_back(bus.instr0);
        if (bus.instr1 != 0) iss.push_back(bus.instr1);
      end
    end
    chk("drain_count", 32'(iss.size()), 32'(acc.size()));
    for (int k = 0; k < iss.size() && k < acc.size(); k++) chk("drain_order", iss[k], acc[k]);

    // Flush with 3 buffered and a valid pair; concurrent push is dropped.
    step(1, F, 0, 0); step(1, ADDI, 0, 0); step(1, SW, 0, 0); step(1, ADD, 0, 0);
    chk("pre_flush_ov", {31'b0, bus.out_valid}, 32'h1);
    step(1, LW, 0, 1);
    chk("flush_ov", {31'b0, bus.out_valid}, 32'h0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step(0, 32'h0, 1, 0);
      chk("post_flush_ov", {31'b0, bus.out_valid}, 32'h0);
    end

    // Asynchronous reset between edges.
    step(1, F, 1, 0); step(1, ADDI, 1, 0); step(1, LW, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("arst_opcode", {26'b0, bus.opcode}, 32'h0);
    chk("arst_opcode1", {26'b0, bus.opcode1}, 32'h0);
    chk("arst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, gen(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_pair.md
ISSUE_PAIR -- requirements
Module: issue_pair

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_instr carries a valid instruction this cycle.
REQ-005 in_instr  input  32  incoming instruction, program order.
REQ-006 in_ready  output  1  buffer can accept in_instr this cycle.
REQ-007 flush  input  1  discard all buffered and pending instructions (taken branch).
REQ-008 out_ready  input  1  downstream dual-issue pipeline accepts the current pair.
REQ-009 out_valid  output  1  instr0/instr1 hold a valid pair.
REQ-010 instr0  output  32  slot-0 instruction (ALU/branch slot), older of pair.
REQ-011 instr1  output  32  slot-1 instruction (memory slot), younger of pair.
REQ-012 opcode, opcode1  output  6 each  instr0[31:26], instr1[31:26], fed to the control decoder.

Function
REQ-013 Instruction buffer SHALL be a 4-entry FIFO; transfer in when in_valid && in_ready.
REQ-014 in_ready SHALL equal (count < 4) from registered count only; no combinational path from out_ready.
REQ-015 Class MEM = opcode 100011 (lw) or 101011 (sw); every other opcode, including unknowns, SHALL be class ALU.
REQ-016 NOP SHALL be 32'h00000000.
REQ-017 Output pair register SHALL load when (!out_valid || out_ready) && count != 0; else hold; out_valid cleared when out_ready && no load.
REQ-018 Head ALU, next entry present, next MEM, no hazard: instr0=head, instr1=next, pop 2.
REQ-019 Head ALU otherwise: instr0=head, instr1=NOP, pop 1.
REQ-020 Head MEM: instr0=NOP, instr1=head, pop 1; a MEM entry SHALL never be paired ahead of an older ALU entry.
REQ-021 Hazard: slot-0 dest (add: [15:11]; addi: [20:16]; beq/bne/other: none) nonzero and equal to slot-1 base [25:21], sw data [20:16], or lw dest [20:16].
REQ-022 Latency: instruction accepted at edge N SHALL be eligible for the output register at edge N+1 (minimum two edges in to out_valid).
REQ-023 Simultaneous push and pop SHALL be supported; count updates by +1 - pops; full FIFO with pop accepts nothing that cycle (in_ready was 0).
REQ-024 Pointers SHALL wrap modulo 4.
REQ-025 flush SHALL at the next edge clear count, pointers and out_valid; flush has priority over push and load in the same cycle (input dropped, in_ready still reflects prior count).
REQ-026 instr0/instr1 SHALL hold stable while out_valid && !out_ready.

Reset
REQ-027 On rst_n low: count=0, pointers=0, out_valid=0, instr0=instr1=NOP, hence opcode=opcode1=000000 and in_ready=1 on the first cycle after release.
REQ-028 Reset asserted mid-operation SHALL discard all contents immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro ISSUE_RAW_CHECK_EN: defined -> REQ-021 hazard check applies; undefined -> hazard forced 0, every ALU head followed by MEM pairs.

Verification
REQ-030 Push 0x20010005 (addi $1) then 0x8C620000 (lw $2,0($3)), out_ready=1 -> one pair instr0=0x20010005, instr1=0x8C620000.
REQ-031 Push 0x20010005 then 0x8C220000 (lw base $1), ISSUE_RAW_CHECK_EN defined -> (0x20010005,NOP) then (NOP,0x8C220000); undefined -> single pair.
REQ-032 Push 0xAC010004 (sw) then 0x00222020 (add) -> (NOP,0xAC010004) then (0x00222020,NOP).
REQ-033 out_ready=0, push 6 instructions -> in_ready low after 4 accepted plus 1 held in output register; instr0/instr1 stable; release drains in order, no loss.
REQ-034 Buffer holding 3 entries, out_valid=1, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, pushed instruction not issued.
REQ-035 Assert rst_n low asynchronously mid-stream -> out_valid=0, opcode=opcode1=000000 before next clk edge, in_ready=1.
